root_newton_iter: RTL

//  Parametrised iterative Newton-Raphson square-root core for the FPU mantissa path.

---
 rtl/root_newton_iter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/root_newton_iter.sv
// root_newton_iter: iterative Newton-Raphson square root for the FPU mantissa path.
// Seeds x ~= 1/sqrt(d) from a 32-entry ROM, refines it ITER times on one shared
// multiplier (SQ -> MD -> UPD, 3 cycles per iteration), then computes sqrt(d) = d*x.
//
// Ports:
//   clock   : rising-edge clock
//   resetn  : synchronous active-low reset
//   start   : request, accepted only while idle
//   recip   : (FSQRT_RECIP_OUT_EN only) return 1/sqrt(d) instead of sqrt(d)
//   d       : radicand fraction 0.d, normalised 0.25 <= d < 1
//   busy    : operation in flight
//   done    : one-cycle pulse, q/inv valid
//   inv     : radicand was below 0.25 at accept
//   q       : result fraction bits, LSB is sticky; held until next done
//
// Optional feature macro: FSQRT_RECIP_OUT_EN (adds the recip input).
module root_newton_iter #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned ITER  = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
`ifdef FSQRT_RECIP_OUT_EN
  input  logic             recip,
`endif
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             inv,
  output logic [WIDTH+7:0] q
);

  localparam int unsigned XW   = WIDTH + 2;      // u2.WIDTH
  localparam int unsigned PW   = 2 * WIDTH + 3;  // widest product actually needed
  localparam int unsigned IT_W = 4;
  localparam logic [IT_W-1:0] ITER_L = IT_W'(ITER);

  typedef enum logic [2:0] {IDLE, SQ, MD, UPD, FIN} state_t;

  state_t          state;
  logic [WIDTH-1:0] reg_d;
  logic [XW-1:0]    x;
  logic [XW-1:0]    t;
  logic [IT_W-1:0]  it;
`ifdef FSQRT_RECIP_OUT_EN
  logic             reg_recip;
`endif

  logic [7:0]    seed_c;
  logic [XW-1:0] mul_a_c;
  logic [XW-1:0] mul_b_c;
  logic [PW-1:0] prod_c;
  logic [XW-1:0] three_minus_t_c;

  // Seed ROM: fraction bits of x0 = 1.seed, indexed by the top five radicand bits
  always_comb begin
    seed_c = 8'hff;
    case (d[WIDTH-1 -: 5])
      5'h08: seed_c = 8'hf0;  5'h09: seed_c = 8'hd5;
      5'h0a: seed_c = 8'hbe;  5'h0b: seed_c = 8'hab;
      5'h0c: seed_c = 8'h99;  5'h0d: seed_c = 8'h8a;
      5'h0e: seed_c = 8'h7c;  5'h0f: seed_c = 8'h6f;
      5'h10: seed_c = 8'h64;  5'h11: seed_c = 8'h5a;
      5'h12: seed_c = 8'h50;  5'h13: seed_c = 8'h47;
      5'h14: seed_c = 8'h3f;  5'h15: seed_c = 8'h38;
      5'h16: seed_c = 8'h31;  5'h17: seed_c = 8'h2a;
      5'h18: seed_c = 8'h24;  5'h19: seed_c = 8'h1e;
      5'h1a: seed_c = 8'h19;  5'h1b: seed_c = 8'h14;
      5'h1c: seed_c = 8'h0f;  5'h1d: seed_c = 8'h0a;
      5'h1e: seed_c = 8'h06;  5'h1f: seed_c = 8'h02;
      default: seed_c = 8'hff;
    endcase
  end

  assign three_minus_t_c = {2'b11, WIDTH'(0)} - t;

  // Shared multiplier operand select
  always_comb begin
    mul_a_c = '0;
    mul_b_c = '0;
    case (state)
      SQ:  begin mul_a_c = x;          mul_b_c = x;               end
      MD:  begin mul_a_c = XW'(reg_d); mul_b_c = t;               end
      UPD: begin mul_a_c = x;          mul_b_c = three_minus_t_c; end
      FIN: begin mul_a_c = XW'(reg_d); mul_b_c = x;               end
      default: ;
    endcase
  end

  // Top product bit (value >= 8) can never be set, so PW drops it
  assign prod_c = PW'(mul_a_c) * PW'(mul_b_c);

  // Sequencer and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      reg_d <= '0;
      x     <= '0;
      t     <= '0;
      it    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      inv   <= 1'b0;
      q     <= '0;
`ifdef FSQRT_RECIP_OUT_EN
      reg_recip <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (d[WIDTH-1:WIDTH-2] == 2'b00) begin
              // Radicand below 0.25: flag it and answer immediately
              done <= 1'b1;
              inv  <= 1'b1;
              q    <= '0;
            end else begin
              reg_d <= d;
              x     <= XW'({2'b01, seed_c}) << (WIDTH - 8);
              it    <= IT_W'(1);
              busy  <= 1'b1;
              state <= SQ;
`ifdef FSQRT_RECIP_OUT_EN
              reg_recip <= recip;
`endif
            end
          end
        end
        SQ: begin
          t     <= prod_c[2*WIDTH+1:WIDTH];
          state <= MD;
        end
        MD: begin
          t     <= prod_c[2*WIDTH+1:WIDTH];
          state <= UPD;
        end
        UPD: begin
          // x <= x*(3-t)/2; halving folded into the slice position
          x  <= prod_c[2*WIDTH+2:WIDTH+1];
          it <= it + IT_W'(1);
          if (it < ITER_L) begin
            state <= SQ;
          end else begin
`ifdef FSQRT_RECIP_OUT_EN
            if (reg_recip) begin
              q     <= {prod_c[2*WIDTH+2:WIDTH+1], 6'b0};
              done  <= 1'b1;
              busy  <= 1'b0;
              inv   <= 1'b0;
              state <= IDLE;
            end else begin
              state <= FIN;
            end
`else
            state <= FIN;
`endif
          end
        end
        FIN: begin
          q     <= {prod_c[2*WIDTH-1 -: WIDTH+7], |prod_c[WIDTH-8:0]};
          done  <= 1'b1;
          busy  <= 1'b0;
          inv   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
